// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: ALU opcodes, major opcodes and branch conditions.
// The alu_op_t encoding is also consumed by the execute-stage alu.
package rv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_PASS = 4'd10,
    ALU_LINK = 4'd11
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; the format is chosen from the opcode.
// Opcodes without an immediate yield zero.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // Format select and sign extension from instr[31]
  always_comb begin
    imm = 32'd0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'd0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline register: one-entry valid/ready stage with flush.
// Decodes the fetched instruction into ALU, branch, memory and writeback controls.
module decode_stage
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [3:0]            alu_sel,
  output logic                  op0_sel,
  output logic                  op1_sel,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic                  reg_write,
  output logic                  is_branch,
  output logic                  is_jal,
  output logic                  is_jalr,
  output logic [2:0]            branch_funct3,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [2:0]            mem_funct3,
  output logic                  illegal
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    alu_op_t               alu;
    logic                  op0;
    logic                  op1;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  is_branch;
    logic                  is_jal;
    logic                  is_jalr;
    logic [2:0]            branch_funct3;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            mem_funct3;
    logic                  illegal;
  } bundle_t;

  logic [31:0] imm_raw;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        accept;
  logic        rw, br, jl, jr, mr, mw, ill;
  bundle_t     dec;
  bundle_t     bundle_d, bundle_q;
  logic        valid_d, valid_q;

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm_raw)
  );

  assign opcode   = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Instruction decode; side-effect flags are cleared for illegal encodings
  always_comb begin
    dec     = '0;
    dec.pc  = in_pc;
    dec.imm = DATA_WIDTH'($signed(imm_raw));
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    dec.alu = ALU_ADD;
    rw  = 1'b0;
    br  = 1'b0;
    jl  = 1'b0;
    jr  = 1'b0;
    mr  = 1'b0;
    mw  = 1'b0;
    ill = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec.op1 = (opcode == OPC_OP_IMM);
        rw      = 1'b1;
        case (f3)
          3'b000:  dec.alu = (opcode == OPC_OP && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu = ALU_SLL;
          3'b010:  dec.alu = ALU_SLT;
          3'b011:  dec.alu = ALU_SLTU;
          3'b100:  dec.alu = ALU_XOR;
          3'b101:  dec.alu = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu = ALU_OR;
          3'b111:  dec.alu = ALU_AND;
          default: dec.alu = ALU_ADD;
        endcase
        // Only shifts carry funct7 on OP-IMM; OP also allows SUB
        if (opcode == OPC_OP) begin
          ill = !((f7 == F7_ZERO) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
        end else begin
          ill = (f3 == 3'b001 && f7 != F7_ZERO) ||
                (f3 == 3'b101 && f7 != F7_ZERO && f7 != F7_ALT);
        end
      end
      OPC_LOAD: begin
        dec.op1        = 1'b1;
        dec.mem_funct3 = f3;
        rw             = 1'b1;
        mr             = 1'b1;
        ill            = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.op1        = 1'b1;
        dec.mem_funct3 = f3;
        mw             = 1'b1;
        ill            = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        dec.op0           = 1'b1;
        dec.op1           = 1'b1;
        dec.branch_funct3 = f3;
        br                = 1'b1;
        ill               = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        dec.alu = ALU_LINK;
        dec.op0 = 1'b1;
        rw      = 1'b1;
        jl      = 1'b1;
      end
      OPC_JALR: begin
        dec.alu = ALU_LINK;
        dec.op0 = 1'b1;
        rw      = 1'b1;
        jr      = 1'b1;
        ill     = (f3 != 3'b000);
      end
      OPC_LUI: begin
        dec.alu = ALU_PASS;
        dec.op1 = 1'b1;
        rw      = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op0 = 1'b1;
        dec.op1 = 1'b1;
        rw      = 1'b1;
      end
      OPC_FENCE: begin
        dec.alu = ALU_ADD;
      end
      default: begin
        ill = 1'b1;
      end
    endcase
    dec.illegal   = ill;
    dec.reg_write = rw && !ill && (dec.rd != 5'd0);
    dec.is_branch = br && !ill;
    dec.is_jal    = jl && !ill;
    dec.is_jalr   = jr && !ill;
    dec.mem_read  = mr && !ill;
    dec.mem_write = mw && !ill;
  end

  // Handshake: flush beats accept, accept beats consume, otherwise hold
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Bundle register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = bundle_q.pc;
  assign alu_sel       = bundle_q.alu;
  assign op0_sel       = bundle_q.op0;
  assign op1_sel       = bundle_q.op1;
  assign imm           = bundle_q.imm;
  assign rs1           = bundle_q.rs1;
  assign rs2           = bundle_q.rs2;
  assign rd            = bundle_q.rd;
  assign reg_write     = bundle_q.reg_write;
  assign is_branch     = bundle_q.is_branch;
  assign is_jal        = bundle_q.is_jal;
  assign is_jalr       = bundle_q.is_jalr;
  assign branch_funct3 = bundle_q.branch_funct3;
  assign mem_read      = bundle_q.mem_read;
  assign mem_write     = bundle_q.mem_write;
  assign mem_funct3    = bundle_q.mem_funct3;
  assign illegal       = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of encoded instructions with hand-derived expected
// bundles, a scoreboard queue, and sequences for stall, flush and reset.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic        op0;
    logic        op1;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        jl;
    logic        jr;
    logic [2:0]  bf3;
    logic        mr;
    logic        mw;
    logic [2:0]  mf3;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [3:0]  alu_sel;
  logic        op0_sel, op1_sel, reg_write, is_branch, is_jal, is_jalr;
  logic        mem_read, mem_write, illegal;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  branch_funct3, mem_funct3;

  exp_t act;
  exp_t q[$];
  exp_t zero_e;
  vec_t vecs[20];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_sel(alu_sel), .op0_sel(op0_sel), .op1_sel(op1_sel), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .branch_funct3(branch_funct3), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .illegal(illegal)
  );

  assign act = {out_pc, alu_sel, op0_sel, op1_sel, imm, rs1, rs2, rd, reg_write,
                is_branch, is_jal, is_jalr, branch_funct3, mem_read, mem_write,
                mem_funct3, illegal};

  function automatic exp_t mk(input logic [3:0] alu, input logic o0, input logic o1,
                              input logic [31:0] im, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] d,
                              input logic rw, input logic br, input logic jl,
                              input logic jr, input logic [2:0] bf, input logic mr,
                              input logic mw, input logic [2:0] mf, input logic il);
    exp_t e;
    e.pc = 32'd0; e.alu = alu; e.op0 = o0; e.op1 = o1; e.imm = im;
    e.rs1 = r1; e.rs2 = r2; e.rd = d; e.rw = rw; e.br = br; e.jl = jl; e.jr = jr;
    e.bf3 = bf; e.mr = mr; e.mw = mw; e.mf3 = mf; e.ill = il;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // One clock: drive inputs, check at negedge against the model, update scoreboard
  task automatic cycle(input logic v, input vec_t t, input logic ordy,
                       input logic fl, input logic r, input logic zchk);
    logic exp_v, exp_rdy;
    in_valid  = v;
    in_instr  = t.instr;
    in_pc     = t.e.pc;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    exp_v   = (q.size() != 0);
    exp_rdy = !exp_v || ordy;
    chk("out_valid", {127'd0, out_valid}, {127'd0, exp_v});
    chk("in_ready", {127'd0, in_ready}, {127'd0, exp_rdy});
    if (zchk) chk("reset_zero", {30'd0, act}, {30'd0, zero_e});
    if (exp_v) begin
      chk("bundle", {30'd0, act}, {30'd0, q[0]});
      if (ordy) void'(q.pop_front());
    end
    if (r || fl) q.delete();
    else if (v && exp_rdy) q.push_back(t.e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    zero_e = '0;
    idle   = '0;
    vecs[0]  = '{32'h002081B3, mk(4'd0, 1'b0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[1]  = '{32'h402081B3, mk(4'd1, 1'b0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[2]  = '{32'hFFF00093, mk(4'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[3]  = '{32'h123452B7, mk(4'd10, 1'b0, 1'b1, 32'h12345000, 5'd8, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[4]  = '{32'hFE208CE3, mk(4'd0, 1'b1, 1'b1, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[5]  = '{32'h010000EF, mk(4'd11, 1'b1, 1'b0, 32'd16, 5'd0, 5'd16, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[6]  = '{32'h00000000, mk(4'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1)};
    vecs[7]  = '{32'h4020F0B3, mk(4'd5, 1'b0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1)};
    vecs[8]  = '{32'hFFC12283, mk(4'd0, 1'b0, 1'b1, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0)};
    vecs[9]  = '{32'h00612423, mk(4'd0, 1'b0, 1'b1, 32'd8, 5'd2, 5'd6, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0)};
    vecs[10] = '{32'h00500013, mk(4'd0, 1'b0, 1'b1, 32'd5, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[11] = '{32'h40345393, mk(4'd4, 1'b0, 1'b1, 32'h403, 5'd8, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[12] = '{32'h40309093, mk(4'd2, 1'b0, 1'b1, 32'h403, 5'd1, 5'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1)};
    vecs[13] = '{32'h004280E7, mk(4'd11, 1'b1, 1'b0, 32'd4, 5'd5, 5'd4, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[14] = '{32'h00001517, mk(4'd0, 1'b1, 1'b1, 32'h1000, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[15] = '{32'h0FF0000F, mk(4'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0)};
    vecs[16] = '{32'hFE20ACE3, mk(4'd0, 1'b1, 1'b1, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1)};
    vecs[17] = '{32'h00613423, mk(4'd0, 1'b0, 1'b1, 32'd8, 5'd2, 5'd6, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1)};
    vecs[18] = '{32'h0000007F, mk(4'd0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1)};
    vecs[19] = '{32'h0000E083, mk(4'd0, 1'b0, 1'b1, 32'h0, 5'd1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1)};
    for (int i = 0; i < 20; i++) vecs[i].e.pc = 32'h1000 + 32'(i) * 32'd4;

    // Reset, then every output must read zero
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b1);

    // Back-to-back decode of the whole table
    for (int i = 0; i < 20; i++) cycle(1'b1, vecs[i], 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure: three stalled cycles, then consume and accept together
    cycle(1'b1, vecs[0], 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, vecs[1], 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, vecs[1], 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush together with an accept
    cycle(1'b1, vecs[2], 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush while stalled drops the held bundle and the incoming one
    cycle(1'b1, vecs[3], 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, vecs[4], 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset while stalled clears everything
    cycle(1'b1, vecs[5], 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, vecs[6], 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, idle, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, vecs[13], 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction decode stage that turns a fetched RV32I instruction into the control and operand-select fields consumed by the execute-stage `alu` and `branch_alu`. It sits between fetch and execute as one pipeline register with a valid/ready handshake and a flush input. It produces the `aluselect` codes the ALU expects, the `funct3` the branch ALU expects, immediates, register indices and memory/writeback controls.

## Interface
- DATA_WIDTH, 32, instruction, PC and immediate width
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage accepts the instruction this cycle
- in_instr  input  32  instruction word
- in_pc  input  DATA_WIDTH  PC of the instruction
- flush  input  1  discard the held and incoming instruction
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute consumes the bundle
- out_pc  output  DATA_WIDTH  registered PC
- alu_sel  output  4  ALU opcode
- op0_sel  output  1  0 = rs1 value, 1 = PC
- op1_sel  output  1  0 = rs2 value, 1 = imm
- imm  output  DATA_WIDTH  sign-extended immediate
- rs1, rs2, rd  output  5  register indices
- reg_write  output  1  write rd at writeback
- is_branch, is_jal, is_jalr  output  1  control-flow class
- branch_funct3  output  3  condition code for `branch_alu`
- mem_read, mem_write  output  1  load/store
- mem_funct3  output  3  access size/sign
- illegal  output  1  undecodable instruction

## Operation
- alu_sel codes: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 SLT, 9 SLTU, 10 PASS input1 (LUI), 11 input0+4 (JAL/JALR link).
- OP (0110011): op0=rs1, op1=rs2. funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0100000 is legal only with funct3 000 (SUB) or 101 (SRA). Any other funct7 other than 0000000 is illegal.
- OP-IMM (0010011): op1=imm (I-type). SLLI requires funct7=0000000. SRLI/SRAI use funct7 0000000/0100000, and other values are illegal. shamt = imm[4:0].
- LOAD (0000011): ADD, rs1 plus imm I, mem_read=1. funct3 011, 110 and 111 are illegal.
- STORE (0100011): ADD, rs1 plus imm S, mem_write=1, reg_write=0. funct3 greater than 010 is illegal.
- BRANCH (1100011): ADD, PC plus imm B (target), is_branch=1, branch_funct3=funct3, reg_write=0. funct3 010 and 011 are illegal.
- JAL (1101111): code 11, op0=PC, imm J, is_jal=1.
- JALR (1100111): code 11, op0=PC, imm I, is_jalr=1. funct3 other than 000 is illegal.
- LUI (0110111): code 10, op1=imm U.
- AUIPC (0010111): ADD, op0=PC, op1=imm U.
- FENCE (0001111): decoded as a NOP, with reg_write, mem_read and mem_write all 0.
- Every other opcode is illegal.
- When illegal=1, reg_write, mem_read, mem_write, is_branch, is_jal and is_jalr are forced to 0, and out_valid still asserts.
- reg_write is forced to 0 when rd=0.
- Immediates are sign-extended from instr[31]. B and J immediates have bit 0 = 0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- in_ready = !out_valid || out_ready (combinational). The stage has no skid buffer.
- Accept occurs when in_valid && in_ready. The bundle register loads and out_valid rises next cycle.
- Consume without new accept: out_valid falls next cycle.
- Simultaneous consume and accept: the new bundle replaces the old one and out_valid stays 1.
- While out_valid && !out_ready, all outputs hold stable.
- flush: out_valid becomes 0 next cycle and any same-cycle accept is discarded. flush takes priority over accept and over stall.
- rst (synchronous) takes priority over flush. Next edge: out_valid=0 and every registered output is 0 (alu_sel=0, imm=0, out_pc=0, illegal=0). in_ready becomes 1.
- Reset mid-stall drops the held bundle.

## Structure
- Package `rv_pkg` holds:
  - the `alu_op_t` enum with the 4-bit codes above, shared with `alu`;
  - opcode localparams;
  - the branch funct3 constants.
- Sub-module `imm_gen` is combinational. It takes instr and produces I/S/B/U/J immediates selected by opcode.
- The decode logic is one always_comb block that feeds one always_ff bundle register.

## Test plan
- `add x3,x1,x2` (0x002081B3), then `sub` (0x402081B3) → alu_sel 0 then 1. rd=3, rs1=1, rs2=2, op1_sel=0, reg_write=1.
- `addi x1,x0,-1` (0xFFF00093) → imm 0xFFFFFFFF, op1_sel=1, alu_sel 0. `lui x5,0x12345` (0x123452B7) → alu_sel 10, imm 0x12345000.
- `beq x1,x2,-8` (0xFE208CE3) → is_branch=1, branch_funct3=000, imm 0xFFFFFFF8, op0_sel=1, reg_write=0. `jal x1,16` (0x010000EF) → alu_sel 11, is_jal=1, imm 16.
- Instructions 0x00000000 and 0x4020F0B3 (funct7 0100000 with AND) → illegal=1, all write/mem/branch flags 0, out_valid=1.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 → in_ready=0 and outputs hold. When out_ready rises, the next instruction is loaded in the same cycle with no bubble and no loss.
- Flush asserted together with an accept, and rst asserted during a stall → out_valid=0 next cycle and the dropped instruction never appears. rst leaves all outputs 0.
